reg_file_scoreboard: RTL and testbench

- 16-entry x 16-bit register file with two read ports, one write port, and a per-register busy scoreboard.
- Consumes the bit-cell storage concept: one row of D flip-flops with write enable per register, read through port muxes.
- Sits between decode (read/issue) and writeback (write/clear busy) in the pipelined CPU.
- Provides write-through bypass and a hazard stall so decode never reads a stale operand.

---
 rtl/reg_file_scoreboard_if.sv | 36 +++
 rtl/reg_file_scoreboard.sv | 98 +++++++++
 tb/tb_reg_file_scoreboard.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_scoreboard_if.sv
// Register file / scoreboard bus.
// Groups the decode-side read/issue signals and the writeback-side write
// signals that connect the pipeline to reg_file_scoreboard.
//   master : pipeline side (decode + writeback), drives indices/data/enables
//   slave  : register file side, returns read data, stall and busy bits
interface reg_file_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] src_reg1;
    logic [ADDR_W-1:0] src_reg2;
    logic [DATA_W-1:0] src_data1;
    logic [DATA_W-1:0] src_data2;
    logic              write_en;
    logic [ADDR_W-1:0] dst_reg;
    logic [DATA_W-1:0] dst_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_reg;
    logic              src_use1;
    logic              src_use2;
    logic              stall;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output src_reg1, src_reg2, write_en, dst_reg, dst_data,
               issue_en, issue_reg, src_use1, src_use2,
        input  src_data1, src_data2, stall, busy_vec
    );

    modport slave (
        input  src_reg1, src_reg2, write_en, dst_reg, dst_data,
               issue_en, issue_reg, src_use1, src_use2,
        output src_data1, src_data2, stall, busy_vec
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
// 16 x 16-bit register file with two combinational read ports, one write
// port, write-through bypass, and a per-register busy scoreboard that
// raises a stall when decode would read an operand still in flight.
// R0 is hard-wired to zero and can never be marked busy.
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (clears registers and busy bits)
//   bus  : reg_file_scoreboard_if.slave
//          read   : src_reg1/2 -> src_data1/2 (combinational)
//          write  : write_en, dst_reg, dst_data (also clears busy)
//          issue  : issue_en, issue_reg (sets busy unless stalled)
//          hazard : src_use1/2 -> stall (combinational), busy_vec (debug)
module reg_file_scoreboard #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    reg_file_scoreboard_if.slave   bus
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_hit1;
    logic              wr_hit2;
    logic              haz1;
    logic              haz2;
    logic              stall;
    logic              wr_valid;

    // Writes to R0 are dropped, so treat them as no write at all.
    assign wr_valid = bus.write_en && (bus.dst_reg != '0);

    assign wr_hit1 = bus.write_en && (bus.dst_reg == bus.src_reg1);
    assign wr_hit2 = bus.write_en && (bus.dst_reg == bus.src_reg2);

    always_comb begin
        rd_data1 = regs_q[bus.src_reg1];
        if (bus.src_reg1 == '0) begin
            rd_data1 = '0;
        end else if (wr_hit1) begin
            rd_data1 = bus.dst_data;
        end
    end

    always_comb begin
        rd_data2 = regs_q[bus.src_reg2];
        if (bus.src_reg2 == '0) begin
            rd_data2 = '0;
        end else if (wr_hit2) begin
            rd_data2 = bus.dst_data;
        end
    end

    // A write landing this cycle resolves the hazard through the bypass.
    assign haz1  = (bus.src_reg1 != '0) && busy_q[bus.src_reg1] && !wr_hit1;
    assign haz2  = (bus.src_reg2 != '0) && busy_q[bus.src_reg2] && !wr_hit2;
    assign stall = (bus.src_use1 && haz1) || (bus.src_use2 && haz2);

    // Set beats clear: a freshly issued producer supersedes the one retiring.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (bus.issue_en && !stall && (bus.issue_reg == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (bus.write_en && (bus.dst_reg == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            if (wr_valid) begin
                regs_q[bus.dst_reg] <= bus.dst_data;
            end
        end
    end

    assign bus.src_data1 = rd_data1;
    assign bus.src_data2 = rd_data2;
    assign bus.stall     = stall;
    assign bus.busy_vec  = busy_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard. Stimulus pushes hand-computed
// expectations into a queue; a monitor on the falling edge pops and compares.
module tb_reg_file_scoreboard;

    localparam int DATA_W = 16;
    localparam int NREG   = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_file_scoreboard_if #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) bus ();

    reg_file_scoreboard #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // care bits: [0] src_data1, [1] src_data2, [2] stall, [3] busy_vec
    typedef struct {
        string       name;
        logic [3:0]  care;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        st;
        logic [15:0] bv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_out(input string name, input logic [3:0] care,
                              input logic [15:0] d1, input logic [15:0] d2,
                              input logic st, input logic [15:0] bv);
        exp_t e;
        e.name = name; e.care = care; e.d1 = d1; e.d2 = d2; e.st = st; e.bv = bv;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write_en  = 1'b0;
        bus.issue_en  = 1'b0;
        bus.src_use1  = 1'b0;
        bus.src_use2  = 1'b0;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.care[0]) begin
                checks++;
                if (bus.src_data1 !== e.d1) begin
                    errors++;
                    $display("FAIL %s src_data1: got %h want %h", e.name, bus.src_data1, e.d1);
                end
            end
            if (e.care[1]) begin
                checks++;
                if (bus.src_data2 !== e.d2) begin
                    errors++;
                    $display("FAIL %s src_data2: got %h want %h", e.name, bus.src_data2, e.d2);
                end
            end
            if (e.care[2]) begin
                checks++;
                if (bus.stall !== e.st) begin
                    errors++;
                    $display("FAIL %s stall: got %b want %b", e.name, bus.stall, e.st);
                end
            end
            if (e.care[3]) begin
                checks++;
                if (bus.busy_vec !== e.bv) begin
                    errors++;
                    $display("FAIL %s busy_vec: got %h want %h", e.name, bus.busy_vec, e.bv);
                end
            end
        end
    end

    initial begin
        bus.src_reg1 = '0; bus.src_reg2 = '0;
        bus.dst_reg = '0; bus.dst_data = '0; bus.issue_reg = '0;
        idle();
        // Reset cycle with write/issue active: both must be ignored.
        bus.write_en = 1'b1; bus.dst_reg = 4'd5; bus.dst_data = 16'h5555;
        bus.issue_en = 1'b1; bus.issue_reg = 4'd3;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // Reset then read
        bus.src_reg1 = 4'd5; bus.src_reg2 = 4'd15;
        bus.src_use1 = 1'b1; bus.src_use2 = 1'b1;
        expect_out("reset_read", 4'b1111, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        step();

        // Write R3 (bypass visible same cycle), then readback
        idle();
        bus.write_en = 1'b1; bus.dst_reg = 4'd3; bus.dst_data = 16'hBEEF;
        bus.src_reg1 = 4'd3;
        expect_out("wr3_bypass", 4'b0001, 16'hBEEF, 16'h0, 1'b0, 16'h0);
        step();
        bus.dst_reg = 4'd0; bus.dst_data = 16'h1234;
        bus.src_reg2 = 4'd0;
        expect_out("wr0_same", 4'b0011, 16'hBEEF, 16'h0000, 1'b0, 16'h0);
        step();
        idle();
        expect_out("readback", 4'b1011, 16'hBEEF, 16'h0000, 1'b0, 16'h0000);
        step();

        // Bypass on both ports
        bus.write_en = 1'b1; bus.dst_reg = 4'd7; bus.dst_data = 16'h0001;
        step();
        bus.dst_data = 16'hA5A5;
        bus.src_reg1 = 4'd7; bus.src_reg2 = 4'd7;
        expect_out("bypass_both", 4'b0011, 16'hA5A5, 16'hA5A5, 1'b0, 16'h0);
        step();
        idle();
        expect_out("bypass_after", 4'b0011, 16'hA5A5, 16'hA5A5, 1'b0, 16'h0);
        step();

        // R0 issue never marks busy
        bus.issue_en = 1'b1; bus.issue_reg = 4'd0;
        step();
        idle();
        expect_out("issue_r0", 4'b1000, 16'h0, 16'h0, 1'b0, 16'h0000);

        // Hazard / stall on R4
        bus.issue_en = 1'b1; bus.issue_reg = 4'd4;
        step();
        idle();
        bus.src_reg1 = 4'd4; bus.src_use1 = 1'b1; bus.src_reg2 = 4'd0;
        expect_out("busy4_stall", 4'b1100, 16'h0, 16'h0, 1'b1, 16'h0010);
        step();
        bus.src_use1 = 1'b0;
        expect_out("unused_nostall", 4'b0100, 16'h0, 16'h0, 1'b0, 16'h0);
        step();
        bus.src_use1 = 1'b1;
        bus.write_en = 1'b1; bus.dst_reg = 4'd4; bus.dst_data = 16'h00FF;
        expect_out("wr4_resolve", 4'b0101, 16'h00FF, 16'h0, 1'b0, 16'h0);
        step();
        idle();
        bus.src_use1 = 1'b1;
        expect_out("busy4_clear", 4'b1101, 16'h00FF, 16'h0, 1'b0, 16'h0000);
        step();

        // Set/clear collision on R9
        idle();
        bus.issue_en = 1'b1; bus.issue_reg = 4'd9;
        step();
        expect_out("busy9_set", 4'b1000, 16'h0, 16'h0, 1'b0, 16'h0200);
        bus.write_en = 1'b1; bus.dst_reg = 4'd9; bus.dst_data = 16'h9999;
        expect_out("collide_nostall", 4'b0100, 16'h0, 16'h0, 1'b0, 16'h0);
        step();
        idle();
        bus.src_reg1 = 4'd9;
        expect_out("collide_after", 4'b1001, 16'h9999, 16'h0, 1'b0, 16'h0200);
        step();

        // Stalled issue must not set busy
        bus.src_use1 = 1'b1;
        bus.issue_en = 1'b1; bus.issue_reg = 4'd2;
        expect_out("stalled_issue", 4'b0100, 16'h0, 16'h0, 1'b1, 16'h0);
        step();
        idle();
        expect_out("busy2_unset", 4'b1000, 16'h0, 16'h0, 1'b0, 16'h0200);

        // Mid-operation reset
        bus.write_en = 1'b1; bus.dst_reg = 4'd6; bus.dst_data = 16'h1111;
        step();
        idle();
        bus.issue_en = 1'b1; bus.issue_reg = 4'd2;
        step();
        bus.issue_reg = 4'd6;
        step();
        idle();
        bus.src_reg1 = 4'd6; bus.src_reg2 = 4'd5;
        expect_out("pre_reset", 4'b1011, 16'h1111, 16'h0000, 1'b0, 16'h0244);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_out("post_reset", 4'b1011, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        step();

        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
